// File: rtl/trace_capture_unit_pkg.sv
// Shared encodings for the trace capture unit: FSM states, trigger modes and a
// width helper for the channel-select ports.
package trace_capture_unit_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] MODE_IMM    = 2'd0;
  localparam logic [1:0] MODE_MATCH  = 2'd1;
  localparam logic [1:0] MODE_CHANGE = 2'd2;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one row holds every channel of a sample. Synchronous write,
// registered read with a channel mux in front of the output register.
module trace_ram
  import trace_capture_unit_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH),
  parameter int CW     = ch_width(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [AW-1:0]            wr_addr,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic [AW-1:0]            rd_addr,
  input  logic [CW-1:0]            rd_ch,
  output logic [DATA_W-1:0]        rd_data
);

  logic [NUM_CH*DATA_W-1:0] mem [DEPTH];
  logic [NUM_CH*DATA_W-1:0] rd_row;
  logic [DATA_W-1:0]        rd_word;

  // NOTE: the array has no reset so it maps onto RAM macros; contents survive reset.
  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_row = mem[rd_addr];

  // NOTE: default assignment first so the mux can never infer a latch.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_ch == CW'(k)) rd_word = rd_row[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_word;
  end

endmodule

// File: rtl/trace_capture_unit.sv
// On-chip trace buffer: circular capture of NUM_CH probe words with immediate,
// match and change triggers, post-trigger window, watchdog and oldest-first readback.
module trace_capture_unit
  import trace_capture_unit_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int POST_TRIG   = 32,
  parameter int CYCLE_LIMIT = 500,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = ch_width(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  input  logic [1:0]               mode,
  input  logic [CW-1:0]            trig_ch,
  input  logic [DATA_W-1:0]        match_value,
  input  logic                     valid_in,
  input  logic [NUM_CH*DATA_W-1:0] probe,
  input  logic [AW-1:0]            rd_addr,
  input  logic [CW-1:0]            rd_ch,
  output logic [DATA_W-1:0]        rd_data,
  output logic [1:0]               state,
  output logic                     done,
  output logic                     triggered,
  output logic                     timeout,
  output logic                     wrapped,
  output logic [AW:0]              sample_count,
  output logic [AW-1:0]            trig_index
);

  localparam int CYW = $clog2(CYCLE_LIMIT + 1);
  localparam logic [CYW-1:0] CYC_LAST  = CYW'(CYCLE_LIMIT);
  localparam logic [AW-1:0]  POST_LAST = AW'(POST_TRIG);
  localparam logic [AW:0]    FULL      = (AW+1)'(DEPTH);

  logic [AW-1:0]     wr_ptr, trig_addr, post_cnt, post_next, oldest;
  logic [CYW-1:0]    cyc_cnt, cyc_next;
  logic [1:0]        mode_q;
  logic [CW-1:0]     trig_ch_q;
  logic [DATA_W-1:0] match_q, prev_q, trig_word;
  logic              have_prev, active, capture, hit, trig_fire, post_end, complete, wd_hit;

  assign active    = (state == ST_ARMED) || (state == ST_POST);
  assign capture   = active && valid_in;
  assign cyc_next  = cyc_cnt + 1'b1;
  assign post_next = post_cnt + 1'b1;

  always_comb begin
    trig_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (trig_ch_q == CW'(k)) trig_word = probe[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    case (mode_q)
      MODE_MATCH:  hit = (trig_word == match_q);
      MODE_CHANGE: hit = have_prev && (trig_word != prev_q);
      default:     hit = 1'b1;
    endcase
  end

  assign trig_fire = capture && (state == ST_ARMED) && hit;
  assign post_end  = capture && (state == ST_POST) && (post_next == POST_LAST);
  assign complete  = post_end || (trig_fire && (POST_TRIG == 0));
  assign wd_hit    = active && (cyc_next == CYC_LAST);

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      sample_count <= '0;
      wrapped      <= 1'b0;
      triggered    <= 1'b0;
      timeout      <= 1'b0;
      cyc_cnt      <= '0;
      post_cnt     <= '0;
      trig_addr    <= '0;
      have_prev    <= 1'b0;
      prev_q       <= '0;
      mode_q       <= MODE_IMM;
      trig_ch_q    <= '0;
      match_q      <= '0;
    end else if (arm) begin
      state        <= ST_ARMED;
      wr_ptr       <= '0;
      sample_count <= '0;
      wrapped      <= 1'b0;
      triggered    <= 1'b0;
      timeout      <= 1'b0;
      cyc_cnt      <= '0;
      post_cnt     <= '0;
      trig_addr    <= '0;
      have_prev    <= 1'b0;
      mode_q       <= mode;
      trig_ch_q    <= trig_ch;
      match_q      <= match_value;
    end else begin
      if (active) cyc_cnt <= cyc_next;
      if (capture) begin
        wr_ptr    <= wr_ptr + 1'b1;
        prev_q    <= trig_word;
        have_prev <= 1'b1;
        if (wr_ptr == '1) wrapped <= 1'b1;
        if (sample_count != FULL) sample_count <= sample_count + 1'b1;
      end
      if (trig_fire) begin
        triggered <= 1'b1;
        trig_addr <= wr_ptr;
        post_cnt  <= '0;
        state     <= (POST_TRIG == 0) ? ST_DONE : ST_POST;
      end
      if (capture && (state == ST_POST)) begin
        post_cnt <= post_next;
        if (post_end) state <= ST_DONE;
      end
      // Normal completion in the same cycle as the watchdog is not a timeout.
      if (wd_hit && !complete) begin
        state   <= ST_DONE;
        timeout <= 1'b1;
      end
    end
  end

  assign done       = (state == ST_DONE);
  assign oldest     = wrapped ? wr_ptr : '0;
  assign trig_index = trig_addr - oldest;

  trace_ram #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW),
    .CW     (CW)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .we      (capture && !arm),
    .wr_addr (wr_ptr),
    .wr_data (probe),
    .rd_addr (oldest + rd_addr),
    .rd_ch   (rd_ch),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_trace_capture_unit.sv
// Directed bench for trace_capture_unit with a small configuration
// (2 channels, 8 entries, 3 post-trigger samples, 20-cycle watchdog).
module tb_trace_capture_unit;

  logic        clock, reset, arm, valid_in;
  logic [1:0]  mode;
  logic [0:0]  trig_ch, rd_ch;
  logic [31:0] match_value, rd_data;
  logic [63:0] probe;
  logic [2:0]  rd_addr, trig_index;
  logic [1:0]  state;
  logic        done, triggered, timeout, wrapped;
  logic [3:0]  sample_count;

  int checks   = 0;
  int failures = 0;

  trace_capture_unit #(
    .NUM_CH(2), .DATA_W(32), .DEPTH(8), .POST_TRIG(3), .CYCLE_LIMIT(20)
  ) dut (
    .clock(clock), .reset(reset), .arm(arm), .mode(mode), .trig_ch(trig_ch),
    .match_value(match_value), .valid_in(valid_in), .probe(probe),
    .rd_addr(rd_addr), .rd_ch(rd_ch), .rd_data(rd_data), .state(state),
    .done(done), .triggered(triggered), .timeout(timeout), .wrapped(wrapped),
    .sample_count(sample_count), .trig_index(trig_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic arm_pulse(input logic [1:0] m, input logic [31:0] mv);
    arm = 1'b1; mode = m; trig_ch = 1'b0; match_value = mv; valid_in = 1'b0;
    tick();
    arm = 1'b0;
  endtask

  task automatic cap(input logic v, input logic [31:0] x);
    valid_in = v;
    probe    = {x + 32'd256, x};
    tick();
    valid_in = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [2:0] a, input logic c, input logic [31:0] exp);
    rd_addr = a; rd_ch = c;
    tick();
    checks++;
    if (rd_data !== exp) begin
      failures++;
      $display("FAIL %s rd_data got=%0d exp=%0d", name, rd_data, exp);
    end
  endtask

  task automatic status_chk(input string name, input logic [1:0] st, input logic [3:0] cnt,
                            input logic trg, input logic to, input logic wr);
    checks++;
    if (state !== st || sample_count !== cnt || triggered !== trg || timeout !== to ||
        wrapped !== wr || done !== (st == 2'd3)) begin
      failures++;
      $display("FAIL %s got state=%0d cnt=%0d trg=%b to=%b wr=%b done=%b exp state=%0d cnt=%0d trg=%b to=%b wr=%b",
               name, state, sample_count, triggered, timeout, wrapped, done, st, cnt, trg, to, wr);
    end
  endtask

  task automatic index_chk(input string name, input logic [2:0] exp);
    checks++;
    if (trig_index !== exp) begin
      failures++;
      $display("FAIL %s trig_index got=%0d exp=%0d", name, trig_index, exp);
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    status_chk("reset_async", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    index_chk("reset_trig_index", 3'd0);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_rd_data got=%0d exp=0", rd_data);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_imm();
    arm_pulse(2'd0, 32'd0);
    status_chk("imm_armed", 2'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    cap(1'b1, 32'd0);
    status_chk("imm_post", 2'd2, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int v = 1; v < 4; v++) cap(1'b1, 32'(v));
    status_chk("imm_done", 2'd3, 4'd4, 1'b1, 1'b0, 1'b0);
    index_chk("imm_trig_index", 3'd0);
    cap(1'b1, 32'd50);
    status_chk("imm_done_hold", 2'd3, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) read_chk("imm_read", 3'(i), 1'b0, 32'(i));
    read_chk("imm_read_ch1", 3'd2, 1'b1, 32'd258);
  endtask

  task automatic test_match();
    arm_pulse(2'd1, 32'd10);
    for (int v = 0; v < 10; v++) cap(1'b1, 32'(v));
    status_chk("match_pre", 2'd1, 4'd8, 1'b0, 1'b0, 1'b1);
    cap(1'b1, 32'd10);
    status_chk("match_post", 2'd2, 4'd8, 1'b1, 1'b0, 1'b1);
    for (int v = 11; v < 14; v++) cap(1'b1, 32'(v));
    status_chk("match_done", 2'd3, 4'd8, 1'b1, 1'b0, 1'b1);
    index_chk("match_trig_index", 3'd4);
    read_chk("match_read0", 3'd0, 1'b0, 32'd6);
    read_chk("match_read7", 3'd7, 1'b0, 32'd13);
    read_chk("match_read4", 3'd4, 1'b0, 32'd10);
  endtask

  task automatic test_watchdog();
    arm_pulse(2'd1, 32'd99);
    for (int v = 0; v < 19; v++) cap(1'b1, 32'(v));
    status_chk("wd_before", 2'd1, 4'd8, 1'b0, 1'b0, 1'b1);
    cap(1'b1, 32'd19);
    status_chk("wd_done", 2'd3, 4'd8, 1'b0, 1'b1, 1'b1);
    read_chk("wd_last_sample", 3'd7, 1'b0, 32'd19);
  endtask

  task automatic test_change();
    arm_pulse(2'd2, 32'd0);
    cap(1'b1, 32'd5);
    status_chk("chg_first", 2'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    cap(1'b0, 32'd77);
    cap(1'b1, 32'd5);
    cap(1'b0, 32'd77);
    cap(1'b1, 32'd5);
    cap(1'b0, 32'd77);
    status_chk("chg_hold", 2'd1, 4'd3, 1'b0, 1'b0, 1'b0);
    cap(1'b1, 32'd9);
    status_chk("chg_fire", 2'd2, 4'd4, 1'b1, 1'b0, 1'b0);
    index_chk("chg_trig_index", 3'd3);
    for (int v = 10; v < 13; v++) cap(1'b1, 32'(v));
    status_chk("chg_done", 2'd3, 4'd7, 1'b1, 1'b0, 1'b0);
    read_chk("chg_read0", 3'd0, 1'b0, 32'd5);
    read_chk("chg_read2", 3'd2, 1'b0, 32'd5);
    read_chk("chg_read3", 3'd3, 1'b0, 32'd9);
    read_chk("chg_read6", 3'd6, 1'b0, 32'd12);
  endtask

  task automatic test_restart();
    arm_pulse(2'd1, 32'd9);
    for (int v = 0; v < 10; v++) cap(1'b1, 32'(v));
    status_chk("rst_post", 2'd2, 4'd8, 1'b1, 1'b0, 1'b1);
    // Re-arm coinciding with a capture cycle: no write, everything clears.
    arm = 1'b1; mode = 2'd1; match_value = 32'd9; valid_in = 1'b1; probe = {32'd0, 32'd200};
    tick();
    arm = 1'b0; valid_in = 1'b0;
    status_chk("rearm_clear", 2'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    index_chk("rearm_trig_index", 3'd0);
    cap(1'b1, 32'd50);
    status_chk("rearm_capture", 2'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    status_chk("reset_armed", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    arm_pulse(2'd0, 32'd0);
    for (int v = 100; v < 104; v++) cap(1'b1, 32'(v));
    status_chk("after_reset_done", 2'd3, 4'd4, 1'b1, 1'b0, 1'b0);
    index_chk("after_reset_trig_index", 3'd0);
    read_chk("after_reset_read0", 3'd0, 1'b0, 32'd100);
    read_chk("after_reset_read3", 3'd3, 1'b0, 32'd103);
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; mode = 2'd0; trig_ch = 1'b0; match_value = 32'd0;
    valid_in = 1'b0; probe = 64'd0; rd_addr = 3'd0; rd_ch = 1'b0;
    test_reset();
    test_imm();
    test_match();
    test_watchdog();
    test_change();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
